// File: rtl/cpu_mem_arbiter.sv
// Arbiter sharing one single-ported memory between the IF and MEM pipeline stages.
// DM has priority; each access holds mem_en for MEM_LATENCY cycles, then acks for one cycle.
module cpu_mem_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic [31:0] conflict_count
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             grant_dm, grant_if, finish;

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_next;
  end

  // The ack flag still high in DONE marks the requester just served; it is not eligible again.
  always_comb begin
    state_next = state;
    grant_dm   = 1'b0;
    grant_if   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (dm_req && !dm_ack) begin
          grant_dm   = 1'b1;
          state_next = BUSY_DM;
        end else if (if_req && !if_ack) begin
          grant_if   = 1'b1;
          state_next = BUSY_IF;
        end else begin
          state_next = IDLE;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (cnt == '0) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt            <= '0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      if_ack         <= 1'b0;
      dm_ack         <= 1'b0;
      if_rdata       <= '0;
      dm_rdata       <= '0;
      conflict_count <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      if (state == IDLE && dm_req && if_req)
        conflict_count <= conflict_count + 32'd1;
      if (grant_dm) begin
        mem_en    <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
        cnt       <= CNT_LOAD;
      end else if (grant_if) begin
        mem_en   <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
        cnt      <= CNT_LOAD;
      end else if (finish) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        if (state == BUSY_DM) begin
          dm_ack <= 1'b1;
          if (!mem_we) dm_rdata <= mem_rdata;
        end else begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end else if (state == BUSY_IF || state == BUSY_DM) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        mem_en <= 1'b0;
      end
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: one instance at MEM_LATENCY=2, one at MEM_LATENCY=1.
module tb_cpu_mem_arbiter;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic        a_if_req, a_dm_req, a_dm_we;
  logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata, a_mem_rdata;
  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_conflict_count;
  logic        a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_stall_if, a_stall_mem;

  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_conflict_count;
  logic        b_if_ack, b_dm_ack, b_mem_en, b_mem_we, b_stall_if, b_stall_mem;

  int checks = 0;
  int errors = 0;

  cpu_mem_arbiter #(.MEM_LATENCY(2), .CNT_W(4)) dut_a (
    .clk(clk), .clr(clr),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_ack(a_dm_ack),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .stall_if(a_stall_if), .stall_mem(a_stall_mem),
    .conflict_count(a_conflict_count)
  );

  cpu_mem_arbiter #(.MEM_LATENCY(1), .CNT_W(4)) dut_b (
    .clk(clk), .clr(clr),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .stall_if(b_stall_if), .stall_mem(b_stall_mem),
    .conflict_count(b_conflict_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  initial begin
    clr = 1'b1;
    a_if_req = 0; a_dm_req = 0; a_dm_we = 0;
    a_if_addr = 0; a_dm_addr = 0; a_dm_wdata = 0; a_mem_rdata = 0;
    b_if_req = 0; b_dm_req = 0; b_dm_we = 0;
    b_if_addr = 0; b_dm_addr = 0; b_dm_wdata = 0; b_mem_rdata = 0;
    step;
    step;
    check("rst_mem_en", {31'd0, a_mem_en}, 32'd0);
    check("rst_mem_addr", a_mem_addr, 32'd0);
    check("rst_acks", {30'd0, a_if_ack, a_dm_ack}, 32'd0);
    check("rst_rdata", a_if_rdata | a_dm_rdata, 32'd0);
    check("rst_conflict", a_conflict_count, 32'd0);
    clr = 1'b0;
    step;

    // Single IF read
    a_if_req = 1; a_if_addr = 32'h100; a_mem_rdata = 32'hDEADBEEF;
    #1;
    check("if_stall_wait", {31'd0, a_stall_if}, 32'd1);
    step;
    check("if_e0_en", {31'd0, a_mem_en}, 32'd1);
    check("if_e0_addr", a_mem_addr, 32'h100);
    check("if_e0_ack", {31'd0, a_if_ack}, 32'd0);
    step;
    check("if_e1_en", {31'd0, a_mem_en}, 32'd1);
    check("if_e1_ack", {31'd0, a_if_ack}, 32'd0);
    check("if_e1_stall", {31'd0, a_stall_if}, 32'd1);
    step;
    check("if_e2_ack", {31'd0, a_if_ack}, 32'd1);
    check("if_e2_rdata", a_if_rdata, 32'hDEADBEEF);
    check("if_e2_en", {31'd0, a_mem_en}, 32'd0);
    check("if_e2_stall", {31'd0, a_stall_if}, 32'd0);
    a_if_req = 0;
    step;
    check("if_e3_ack", {31'd0, a_if_ack}, 32'd0);
    check("if_e3_hold", a_if_rdata, 32'hDEADBEEF);

    // Simultaneous requests: DM first, IF granted from DONE
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h200;
    a_if_req = 1; a_if_addr = 32'h104; a_mem_rdata = 32'h11112222;
    step;
    check("cf_e0_addr", a_mem_addr, 32'h200);
    check("cf_e0_en", {31'd0, a_mem_en}, 32'd1);
    check("cf_count", a_conflict_count, 32'd1);
    step;
    step;
    check("cf_e2_dmack", {31'd0, a_dm_ack}, 32'd1);
    check("cf_e2_dmrdata", a_dm_rdata, 32'h11112222);
    check("cf_e2_ifack", {31'd0, a_if_ack}, 32'd0);
    check("cf_e2_stalls", {30'd0, a_stall_if, a_stall_mem}, 32'd2);
    a_dm_req = 0; a_mem_rdata = 32'h33334444;
    step;
    check("cf_e3_addr", a_mem_addr, 32'h104);
    check("cf_e3_en", {31'd0, a_mem_en}, 32'd1);
    check("cf_e3_dmack", {31'd0, a_dm_ack}, 32'd0);
    step;
    check("cf_e4_ifack", {31'd0, a_if_ack}, 32'd0);
    step;
    check("cf_e5_ifack", {31'd0, a_if_ack}, 32'd1);
    check("cf_e5_ifrdata", a_if_rdata, 32'h33334444);
    a_if_req = 0;
    step;
    check("cf_count_final", a_conflict_count, 32'd1);

    // Preload dm_rdata with a read, then a write must leave it untouched
    a_dm_req = 1; a_dm_we = 0; a_dm_addr = 32'h44; a_mem_rdata = 32'hAAAA5555;
    step; step; step;
    check("wr_pre_rdata", a_dm_rdata, 32'hAAAA5555);
    a_dm_req = 0;
    step;
    a_dm_req = 1; a_dm_we = 1; a_dm_addr = 32'h40; a_dm_wdata = 32'h12345678;
    a_mem_rdata = 32'hBAD0BAD0;
    step;
    check("wr_e0_we", {30'd0, a_mem_en, a_mem_we}, 32'd3);
    check("wr_e0_wdata", a_mem_wdata, 32'h12345678);
    check("wr_e0_addr", a_mem_addr, 32'h40);
    step;
    check("wr_e1_we", {30'd0, a_mem_en, a_mem_we}, 32'd3);
    step;
    check("wr_e2_ack", {31'd0, a_dm_ack}, 32'd1);
    check("wr_e2_we", {31'd0, a_mem_we}, 32'd0);
    check("wr_e2_rdata", a_dm_rdata, 32'hAAAA5555);
    a_dm_req = 0; a_dm_we = 0;
    step;

    // Reset during a DM read
    a_dm_req = 1; a_dm_addr = 32'h80; a_mem_rdata = 32'h99999999;
    step;
    check("rs_e0_en", {31'd0, a_mem_en}, 32'd1);
    clr = 1;
    step;
    clr = 0;
    a_dm_req = 0;
    check("rs_e1_en", {30'd0, a_mem_en, a_mem_we}, 32'd0);
    check("rs_e1_addr", a_mem_addr | a_mem_wdata, 32'd0);
    check("rs_e1_ack", {31'd0, a_dm_ack}, 32'd0);
    check("rs_e1_rdata", a_dm_rdata | a_if_rdata, 32'd0);
    check("rs_e1_count", a_conflict_count, 32'd0);
    step;
    check("rs_e2_idle", {30'd0, a_mem_en, a_dm_ack}, 32'd0);
    a_dm_req = 1; a_dm_addr = 32'h84; a_mem_rdata = 32'h55667788;
    step;
    check("rs_e3_en", {31'd0, a_mem_en}, 32'd1);
    check("rs_e3_addr", a_mem_addr, 32'h84);
    step;
    step;
    check("rs_e5_ack", {31'd0, a_dm_ack}, 32'd1);
    check("rs_e5_rdata", a_dm_rdata, 32'h55667788);
    a_dm_req = 0;
    step;

    // Conflict counter wrap
    force dut_a.conflict_count = 32'hFFFFFFFF;
    #1;
    release dut_a.conflict_count;
    a_dm_req = 1; a_if_req = 1;
    step;
    check("wrap_count", a_conflict_count, 32'd0);
    a_dm_req = 0; a_if_req = 0;

    // MEM_LATENCY=1 with IF continuously requesting
    b_if_req = 1; b_if_addr = 32'h300; b_mem_rdata = 32'hCAFEF00D;
    step;
    check("ml_e0_en", {31'd0, b_mem_en}, 32'd1);
    check("ml_e0_ack", {31'd0, b_if_ack}, 32'd0);
    step;
    check("ml_e1_ack", {31'd0, b_if_ack}, 32'd1);
    check("ml_e1_rdata", b_if_rdata, 32'hCAFEF00D);
    check("ml_e1_en", {31'd0, b_mem_en}, 32'd0);
    b_dm_req = 1; b_dm_addr = 32'h400; b_mem_rdata = 32'h0BADF00D;
    step;
    check("ml_e2_en", {31'd0, b_mem_en}, 32'd1);
    check("ml_e2_addr", b_mem_addr, 32'h400);
    check("ml_e2_ifack", {31'd0, b_if_ack}, 32'd0);
    step;
    check("ml_e3_dmack", {31'd0, b_dm_ack}, 32'd1);
    check("ml_e3_dmrdata", b_dm_rdata, 32'h0BADF00D);
    b_dm_req = 0; b_mem_rdata = 32'h76543210;
    step;
    check("ml_e4_addr", b_mem_addr, 32'h300);
    check("ml_e4_en", {31'd0, b_mem_en}, 32'd1);
    step;
    check("ml_e5_ack", {31'd0, b_if_ack}, 32'd1);
    check("ml_e5_rdata", b_if_rdata, 32'h76543210);
    check("ml_count", b_conflict_count, 32'd0);
    b_if_req = 0;
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
